contrast_stretch_ctrl: RTL and testbench
========================================

Name: contrast_stretch_ctrl

Overview:
Auto-contrast controller for the contrast-stretch datapath. It snoops the pixel stream and tracks per-frame min/max luminance. At end of frame it computes the Q8.8 gain 255/(max-min) with an iterative divider, then publishes a new min/max/gain set. The stretch datapath latches this set at its next start of frame and computes out = clamp(((p - cfg_min) * cfg_scale) >> 8, 0, 255).

Parameters:
DEF_MIN, 50, fallback/reset low threshold.
DEF_MAX, 200, fallback/reset high threshold.
MIN_RANGE, 16, smallest max-min treated as valid; smaller ranges are degenerate and commit the defaults.
SCALE_W, 16, width of the Q8.8 gain output.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
enable  input  1  1 = auto-contrast; 0 = commit bypass (0/255/256). Sampled in COMMIT.
pix_valid  input  1  pixel qualifier; the controller never stalls the stream.
pix_data  input  8  pixel value.
pix_last  input  1  last pixel of frame; meaningful only when pix_valid=1.
cfg_min  output  8  committed low threshold.
cfg_max  output  8  committed high threshold.
cfg_scale  output  SCALE_W  committed gain, Q8.8 = floor(65280/(cfg_max-cfg_min)).
cfg_update  output  1  one-cycle pulse when the cfg_* outputs change.
busy  output  1  high in DIVIDE and COMMIT.
degenerate  output  1  high with cfg_update when the range was below MIN_RANGE; low otherwise.
overrun  output  1  sticky; set when a frame ends while busy. Cleared only by rst.

Behaviour:
- Reset (rst=1 at an edge): cfg_min=DEF_MIN, cfg_max=DEF_MAX, cfg_scale=floor(65280/(DEF_MAX-DEF_MIN)) (435 at defaults). cfg_update=0, busy=0, degenerate=0, overrun=0, state=ACCUM, run_min=255, run_max=0, divider cleared. Reset mid-DIVIDE abandons the computation with no cfg_update.
- Accumulator runs in every state. On each pix_valid: run_min=min(run_min,pix_data) and run_max=max(run_max,pix_data).
- On pix_valid&pix_last: the frame result includes the current pixel; run_min/run_max reinit to 255/0 on the same edge.
- FSM states: ACCUM, DIVIDE, COMMIT.
- ACCUM -> DIVIDE on pix_valid&pix_last:
  - snapshot snap_min/snap_max including the last pixel;
  - range = snap_max - snap_min (8-bit, unsigned, never negative);
  - the divider loads numerator 65280 (16b) and denominator {8'b0,range}; iteration count = 0.
- DIVIDE: restoring divide, one quotient bit per cycle, exactly 16 cycles; then -> COMMIT. Range 0 is not special-cased in DIVIDE, so the quotient is garbage but ignored because the range is degenerate.
- COMMIT (1 cycle) -> ACCUM. Output registers update on the COMMIT edge, in priority order:
  1. enable=0: 0/255/256, degenerate=0.
  2. range < MIN_RANGE: DEF_MIN/DEF_MAX/default scale, degenerate=1.
  3. Otherwise: snap_min/snap_max/quotient[SCALE_W-1:0], degenerate=0.
- Latency: if pix_last is sampled at edge N, cfg_* and cfg_update=1 become visible after edge N+17. cfg_update stays high exactly one cycle.
- busy=1 from edge N through edge N+17.
- If pix_valid&pix_last arrives while state is DIVIDE or COMMIT:
  - that frame's stats are discarded and overrun is set;
  - the accumulator still reinits;
  - the in-flight computation is unaffected.
- Outputs hold their values between commits. cfg_* is never partially updated.
- Quotient bounds: with MIN_RANGE>=1, max quotient 65280 fits 16 bits. At MIN_RANGE=16 the max is 4080.

Decomposition:
- Package contrast_pkg:
  - PIX_W=8;
  - the NUMERATOR=65280 constant;
  - default-scale function floor(65280/(DEF_MAX-DEF_MIN));
  - state enum {ACCUM, DIVIDE, COMMIT};
  - BYPASS_MIN=0, BYPASS_MAX=255, BYPASS_SCALE=256.
- One sub-module: cs_recip_div. A 16-bit iterative restoring divider with ports clk, rst, start, num, den, done, quot. Fixed 16-cycle latency; start is ignored while running.

Test Plan:
- Reset: after rst pulse, cfg_min=50, cfg_max=200, cfg_scale=435, cfg_update=0, busy=0, overrun=0.
- Normal frame: 64 pixels spanning 20..220 (enable=1), last sampled at edge N -> after edge N+17 cfg_min=20, cfg_max=220, cfg_scale=326, degenerate=0, one-cycle cfg_update.
- Degenerate: a 32-pixel frame all 100, and separately a 1-pixel frame of 7 with pix_last -> 50/200/435 with degenerate=1.
- Back-to-back: frame A (range 40..140 -> scale 652) followed immediately by 8-pixel frame B ending during DIVIDE -> only A committed, overrun=1 and stays 1. Frame C (0..255) afterwards commits 0/255/256 normally.
- Bypass: enable=0 at COMMIT with frame 30..90 -> 0/255/256, degenerate=0; enable=1 on the next frame restores computed values.
- Reset mid-divide: rst asserted 5 cycles after pix_last -> reset values, no cfg_update, busy=0. The next full frame commits correctly.

Source files
------------

// File: rtl/contrast_stretch_ctrl_pkg.sv
// Shared constants, state encoding and default-gain helper for the auto-contrast controller.
package contrast_pkg;
  localparam int          PIX_W        = 8;
  localparam logic [15:0] NUMERATOR    = 16'd65280;
  localparam logic [7:0]  BYPASS_MIN   = 8'd0;
  localparam logic [7:0]  BYPASS_MAX   = 8'd255;
  localparam logic [15:0] BYPASS_SCALE = 16'd256;

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    DIVIDE = 2'd1,
    COMMIT = 2'd2
  } state_t;

  // Q8.8 gain for a fixed threshold pair, evaluated at elaboration time.
  function automatic logic [15:0] default_scale(input int unsigned lo, input int unsigned hi);
    int unsigned q;
    q = 32'd65280 / (hi - lo);
    return q[15:0];
  endfunction
endpackage

// File: rtl/contrast_stretch_ctrl_recip.sv
// 16-bit iterative restoring divider: one quotient bit per cycle, fixed 16-cycle latency.
module cs_recip_div
  import contrast_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] num,
  input  logic [15:0] den,
  output logic        done,
  output logic [15:0] quot
);
  logic        running;
  logic [3:0]  cnt;
  logic [15:0] rem;
  logic [15:0] den_q;
  logic [16:0] shifted;
  logic [16:0] trial;

  // quot doubles as the dividend shift register; bits leave at the top as quotient bits enter.
  always_comb begin
    shifted = {rem, quot[15]};
    trial   = shifted - {1'b0, den_q};
  end

  // done marks the edge on which the final quotient bit is written.
  assign done = running && (cnt == 4'd15);

  // Iteration engine; a start while running is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      running <= 1'b0;
      cnt     <= 4'd0;
      rem     <= 16'd0;
      den_q   <= 16'd0;
      quot    <= 16'd0;
    end else if (!running) begin
      if (start) begin
        running <= 1'b1;
        cnt     <= 4'd0;
        rem     <= 16'd0;
        den_q   <= den;
        quot    <= num;
      end
    end else begin
      rem  <= trial[16] ? shifted[15:0] : trial[15:0];
      quot <= {quot[14:0], ~trial[16]};
      cnt  <= cnt + 4'd1;
      if (cnt == 4'd15) begin
        running <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/contrast_stretch_ctrl.sv
// Auto-contrast controller: tracks per-frame min/max, divides for the Q8.8 gain and
// publishes a complete min/max/gain set one cycle after the divide finishes.
module contrast_stretch_ctrl
  import contrast_pkg::*;
#(
  parameter int DEF_MIN   = 50,
  parameter int DEF_MAX   = 200,
  parameter int MIN_RANGE = 16,
  parameter int SCALE_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               pix_valid,
  input  logic [PIX_W-1:0]   pix_data,
  input  logic               pix_last,
  output logic [PIX_W-1:0]   cfg_min,
  output logic [PIX_W-1:0]   cfg_max,
  output logic [SCALE_W-1:0] cfg_scale,
  output logic               cfg_update,
  output logic               busy,
  output logic               degenerate,
  output logic               overrun
);
  localparam logic [PIX_W-1:0]   DEF_MIN_V   = PIX_W'(DEF_MIN);
  localparam logic [PIX_W-1:0]   DEF_MAX_V   = PIX_W'(DEF_MAX);
  localparam logic [SCALE_W-1:0] DEF_SCALE_V = SCALE_W'(default_scale(DEF_MIN, DEF_MAX));
  localparam logic [PIX_W-1:0]   MIN_RANGE_V = PIX_W'(MIN_RANGE);

  state_t           state;
  logic [PIX_W-1:0] run_min;
  logic [PIX_W-1:0] run_max;
  logic [PIX_W-1:0] snap_min;
  logic [PIX_W-1:0] snap_max;
  logic [PIX_W-1:0] frame_min;
  logic [PIX_W-1:0] frame_max;
  logic [PIX_W-1:0] frame_range;
  logic [PIX_W-1:0] snap_range;
  logic             frame_end;
  logic             div_start;
  logic             div_done;
  logic [15:0]      div_quot;

  // Frame statistics including the pixel currently on the bus.
  always_comb begin
    frame_min   = (pix_data < run_min) ? pix_data : run_min;
    frame_max   = (pix_data > run_max) ? pix_data : run_max;
    frame_range = frame_max - frame_min;
    snap_range  = snap_max - snap_min;
    frame_end   = pix_valid & pix_last;
    div_start   = frame_end && (state == ACCUM);
  end

  cs_recip_div u_div (
    .clk   (clk),
    .rst   (rst),
    .start (div_start),
    .num   (NUMERATOR),
    .den   ({8'd0, frame_range}),
    .done  (div_done),
    .quot  (div_quot)
  );

  // Running min/max; keeps accumulating in every state so no pixel is ever stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_min <= 8'd255;
      run_max <= 8'd0;
    end else if (pix_valid) begin
      if (pix_last) begin
        run_min <= 8'd255;
        run_max <= 8'd0;
      end else begin
        run_min <= frame_min;
        run_max <= frame_max;
      end
    end
  end

  // Control FSM with registered outputs; a frame ending while busy is dropped and flagged.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ACCUM;
      snap_min   <= 8'd0;
      snap_max   <= 8'd0;
      cfg_min    <= DEF_MIN_V;
      cfg_max    <= DEF_MAX_V;
      cfg_scale  <= DEF_SCALE_V;
      cfg_update <= 1'b0;
      busy       <= 1'b0;
      degenerate <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      cfg_update <= 1'b0;
      degenerate <= 1'b0;
      if (frame_end && (state != ACCUM)) begin
        overrun <= 1'b1;
      end
      case (state)
        ACCUM: begin
          if (frame_end) begin
            snap_min <= frame_min;
            snap_max <= frame_max;
            busy     <= 1'b1;
            state    <= DIVIDE;
          end
        end
        DIVIDE: begin
          if (div_done) begin
            state <= COMMIT;
          end
        end
        COMMIT: begin
          cfg_update <= 1'b1;
          busy       <= 1'b0;
          state      <= ACCUM;
          if (!enable) begin
            cfg_min   <= BYPASS_MIN;
            cfg_max   <= BYPASS_MAX;
            cfg_scale <= SCALE_W'(BYPASS_SCALE);
          end else if (snap_range < MIN_RANGE_V) begin
            cfg_min    <= DEF_MIN_V;
            cfg_max    <= DEF_MAX_V;
            cfg_scale  <= DEF_SCALE_V;
            degenerate <= 1'b1;
          end else begin
            cfg_min   <= snap_min;
            cfg_max   <= snap_max;
            cfg_scale <= div_quot[SCALE_W-1:0];
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ACCUM;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_contrast_stretch_ctrl.sv
// Directed-plus-random bench for contrast_stretch_ctrl with a frame-level reference model.
module tb_contrast_stretch_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        pix_valid;
  logic [7:0]  pix_data;
  logic        pix_last;
  logic [7:0]  cfg_min;
  logic [7:0]  cfg_max;
  logic [15:0] cfg_scale;
  logic        cfg_update;
  logic        busy;
  logic        degenerate;
  logic        overrun;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int fr_min, fr_max, last_edge, a_edge, upd_seen;

  contrast_stretch_ctrl dut (
    .clk(clk), .rst(rst), .enable(enable),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_last(pix_last),
    .cfg_min(cfg_min), .cfg_max(cfg_max), .cfg_scale(cfg_scale),
    .cfg_update(cfg_update), .busy(busy), .degenerate(degenerate), .overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic l);
    @(negedge clk);
    pix_valid = v;
    pix_data  = d;
    pix_last  = l;
  endtask

  // Sends n pixels in [lo,hi] (lo first, hi last) with occasional idle gaps carrying a stray last.
  task automatic send_frame(input int n, input int lo, input int hi);
    int v;
    fr_min = 255;
    fr_max = 0;
    for (int i = 0; i < n; i++) begin
      if (i > 0 && $urandom_range(3, 0) == 0) drive(1'b0, 8'($urandom_range(255, 0)), 1'b1);
      v = (i == 0) ? lo : (i == n - 1) ? hi : $urandom_range(hi, lo);
      if (v < fr_min) fr_min = v;
      if (v > fr_max) fr_max = v;
      drive(1'b1, 8'(v), i == n - 1);
    end
    @(negedge clk);
    pix_valid = 1'b0;
    pix_last  = 1'b0;
    last_edge = cyc;
  endtask

  // Reference outcome of one frame from the published rules.
  task automatic expect_commit(input string tag, input int ref_edge, input bit en,
                               input int mn, input int mx);
    int em, eM, es, ed, waited;
    if (!en) begin
      em = 0; eM = 255; es = 256; ed = 0;
    end else if (mx - mn < 16) begin
      em = 50; eM = 200; es = 65280 / 150; ed = 1;
    end else begin
      em = mn; eM = mx; es = 65280 / (mx - mn); ed = 0;
    end
    chk({tag, ".busy_pre"}, busy, 1);
    waited = 0;
    while (cfg_update !== 1'b1 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    chk({tag, ".latency"}, cyc - ref_edge, 17);
    chk({tag, ".min"}, cfg_min, em);
    chk({tag, ".max"}, cfg_max, eM);
    chk({tag, ".scale"}, cfg_scale, es);
    chk({tag, ".degen"}, degenerate, ed);
    chk({tag, ".busy_post"}, busy, 0);
    @(negedge clk);
    chk({tag, ".pulse"}, cfg_update, 0);
    chk({tag, ".hold_scale"}, cfg_scale, es);
  endtask

  task automatic count_updates(input int cycles);
    upd_seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (cfg_update === 1'b1) upd_seen++;
    end
  endtask

  initial begin
    int lo, hi;
    rst = 1'b1; enable = 1'b1; pix_valid = 1'b0; pix_data = 8'd0; pix_last = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst.min", cfg_min, 50);
    chk("rst.max", cfg_max, 200);
    chk("rst.scale", cfg_scale, 435);
    chk("rst.update", cfg_update, 0);
    chk("rst.busy", busy, 0);
    chk("rst.overrun", overrun, 0);
    chk("rst.degen", degenerate, 0);

    send_frame(64, 20, 220);
    expect_commit("normal", last_edge, 1'b1, fr_min, fr_max);

    send_frame(32, 100, 100);
    expect_commit("flat", last_edge, 1'b1, fr_min, fr_max);
    send_frame(1, 7, 7);
    expect_commit("single", last_edge, 1'b1, fr_min, fr_max);

    send_frame(20, 100, 116);
    expect_commit("range16", last_edge, 1'b1, fr_min, fr_max);
    send_frame(20, 100, 115);
    expect_commit("range15", last_edge, 1'b1, fr_min, fr_max);
    for (int k = 0; k < 3; k++) begin
      lo = $urandom_range(120, 0);
      hi = lo + $urandom_range(255 - lo, 0);
      send_frame($urandom_range(40, 2), lo, hi);
      expect_commit("random", last_edge, 1'b1, fr_min, fr_max);
    end

    chk("b2b.overrun_pre", overrun, 0);
    send_frame(16, 40, 140);
    a_edge = last_edge;
    send_frame(8, 10, 250);
    chk("b2b.overrun_set", overrun, 1);
    expect_commit("b2b.A", a_edge, 1'b1, 40, 140);
    count_updates(25);
    chk("b2b.no_B_commit", upd_seen, 0);
    send_frame(24, 0, 255);
    expect_commit("b2b.C", last_edge, 1'b1, fr_min, fr_max);
    chk("b2b.overrun_sticky", overrun, 1);

    enable = 1'b0;
    send_frame(24, 30, 90);
    expect_commit("bypass", last_edge, 1'b0, fr_min, fr_max);
    enable = 1'b1;
    send_frame(24, 30, 90);
    expect_commit("restore", last_edge, 1'b1, fr_min, fr_max);

    send_frame(24, 5, 180);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst.min", cfg_min, 50);
    chk("midrst.max", cfg_max, 200);
    chk("midrst.scale", cfg_scale, 435);
    chk("midrst.busy", busy, 0);
    chk("midrst.update", cfg_update, 0);
    chk("midrst.overrun", overrun, 0);
    count_updates(25);
    chk("midrst.no_commit", upd_seen, 0);
    send_frame(32, 10, 250);
    expect_commit("after_rst", last_edge, 1'b1, fr_min, fr_max);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
